wb_stage_buffered: RTL and testbench
====================================

// Module: wb_stage_buffered
// PURPOSE
//  Buffered write-back stage: successor to the fixed single-cycle write-back mux.
//  Accepts MEM-stage results through a valid/ready handshake and holds them in an in-order queue.
//  Pairs each load with its variable-latency data-memory response, then byte-lane-selects,
//  extends and retires one register write per cycle.
//  Sits between the MEM stage / dmem response port and the register file write port.
// PARAMETERS
//  DEPTH       4  pending-entry queue depth; also sizes the response buffer (power of 2, >=2)
//  REG_ADDR_W  5  register specifier width
//  ZERO_DROP   1  1: retirements targeting register 0 retire with reg_write=0
// PORTS
//  clk            in   1           rising-edge clock
//  rst_n          in   1           asynchronous active-low reset
//  in_valid       in   1           MEM-stage entry present
//  in_ready       out  1           queue can accept (combinational: count<DEPTH)
//  in_reg_write   in   1           entry writes a register
//  in_is_load     in   1           entry result comes from data memory
//  in_dmem_info   in   3           [0]=unsigned, [1]=word, [2]=half (else byte)
//  in_alu_out     in   32          ALU result; load byte address for loads
//  in_write_reg   in   REG_ADDR_W  destination register
//  mem_rsp_valid  in   1           data-memory read response valid (in load order)
//  mem_rsp_data   in   32          response word, big-endian ([0:7] = byte offset 0)
//  reg_write      out  1           registered write enable, one-cycle pulse per retirement
//  write_reg_wb   out  REG_ADDR_W  registered destination
//  write_data     out  32          registered write data
//  pend_count     out  clog2(DEPTH)+1  entries in queue
//  rsp_overflow   out  1           sticky: response with no outstanding load, or response buffer full
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - queue and response buffer empty; outstanding-load count 0.
//   - reg_write=0, write_reg_wb=0, write_data=0, pend_count=0, rsp_overflow=0.
//   - Reset mid-operation discards all pending entries and buffered responses.
//  Accept:
//   - in_valid & in_ready pushes {reg_write, is_load, dmem_info, alu_out[30:31], alu_out, write_reg}.
//   - An is_load push increments the outstanding-load count.
//  Response:
//   - mem_rsp_valid pushes the data into the response buffer.
//   - If outstanding loads (including one accepted the same cycle) equal the buffered
//     responses, or the buffer is full: drop the data and set rsp_overflow.
//  Retire (at most one per cycle, head only):
//   - Non-load head: always retires.
//   - Load head: retires only when the response buffer is non-empty; the buffer head is
//     popped and the outstanding count decremented.
//   - A response arriving this cycle is not usable this cycle (registered buffer).
//  Latency:
//   - Non-load accepted into an empty queue at edge t: outputs valid after edge t+1.
//   - Load: outputs valid one edge after the edge that captured its response.
//  Data formation (loads, off = address bits [30:31]):
//   - word:  mem_rsp_data; off ignored.
//   - half:  lane [0:15] if off[0]==0 (offset 0), else lane [16:31]; off[1] ignored;
//            zero-extend if unsigned, else sign-extend from lane MSB.
//   - byte:  lane [8*off : 8*off+7]; zero- or sign-extend.
//   - Non-load: write_data = alu_out.
//  Write enable:
//   - reg_write = entry reg_write, forced 0 when ZERO_DROP and write_reg_wb==0.
//   - write_reg_wb and write_data still update on that retirement.
//   - No retirement: reg_write=0; write_reg_wb and write_data hold.
//  Full/empty:
//   - Push and pop in the same cycle when full is legal only because in_ready is low
//     when full; push is blocked.
//   - Push and pop when non-full and non-empty: count unchanged.
//   - Empty queue: nothing retires; responses still buffer.
//  Wrap-around:
//   - Read/write pointers wrap modulo DEPTH; count distinguishes full from empty.
// TESTING
//  1. Non-load alu_out=0x12345678, reg 7, into empty queue -> one cycle later:
//     reg_write=1, write_reg_wb=7, write_data=0x12345678.
//  2. Signed byte load at addr ...02, rsp 0x0011F0FF 3 cycles later -> write_data=0xFFFFFFF0;
//     same as unsigned -> 0x000000F0.
//  3. Signed half at addr ...02, rsp 0x0000_8001 -> 0xFFFF8001; at addr ...00 -> 0x00000000.
//  4. Fill DEPTH loads with no responses -> in_ready=0, pend_count=DEPTH;
//     feed DEPTH responses -> DEPTH in-order retirements, pointers wrap, in_ready returns 1.
//  5. mem_rsp_valid with no outstanding load -> rsp_overflow=1 and stays set;
//     no retirement occurs.
//  6. Entry to reg 0 with ZERO_DROP=1 -> reg_write=0; rst_n low mid-stream with 3 pending
//     -> all outputs 0, pend_count=0 immediately.

Source files
------------

// File: rtl/wb_stage_buffered.sv
// Buffered write-back stage: in-order queue of MEM-stage results, paired with
// variable-latency load responses, retiring at most one register write per cycle.
module wb_stage_buffered #(
  parameter int DEPTH      = 4,
  parameter int REG_ADDR_W = 5,
  parameter int ZERO_DROP  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_reg_write,
  input  logic                    in_is_load,
  input  logic [2:0]              in_dmem_info,
  input  logic [31:0]             in_alu_out,
  input  logic [REG_ADDR_W-1:0]   in_write_reg,
  input  logic                    mem_rsp_valid,
  input  logic [31:0]             mem_rsp_data,
  output logic                    reg_write,
  output logic [REG_ADDR_W-1:0]   write_reg_wb,
  output logic [31:0]             write_data,
  output logic [$clog2(DEPTH):0]  pend_count,
  output logic                    rsp_overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic                  r_q_rw   [DEPTH];
  logic                  r_q_ld   [DEPTH];
  logic [2:0]            r_q_info [DEPTH];
  logic [31:0]           r_q_alu  [DEPTH];
  logic [REG_ADDR_W-1:0] r_q_reg  [DEPTH];
  logic [31:0]           r_rb     [DEPTH];

  logic [PW-1:0]         r_wp, r_rp, r_rb_wp, r_rb_rp;
  logic [CW-1:0]         r_cnt, r_ld_cnt, r_rb_cnt;
  logic                  r_ovf;
  logic                  r_reg_write;
  logic [REG_ADDR_W-1:0] r_wreg;
  logic [31:0]           r_wdata;

  logic                  w_push, w_push_ld, w_pop, w_rsp_pop, w_rsp_push, w_rsp_drop;
  logic                  w_head_ld, w_wen;
  logic [CW-1:0]         w_ld_pend;
  logic [31:0]           w_hd_data;

  // Response word is big-endian: byte offset 0 lives in bits [31:24].
  function automatic logic [31:0] form_load(input logic [2:0] info, input logic [1:0] off,
                                            input logic [31:0] d);
    logic [15:0] h;
    logic [7:0]  b;
    h = off[1] ? d[15:0] : d[31:16];
    case (off)
      2'd0:    b = d[31:24];
      2'd1:    b = d[23:16];
      2'd2:    b = d[15:8];
      default: b = d[7:0];
    endcase
    if (info[1])      return d;
    else if (info[2]) return info[0] ? {16'b0, h} : {{16{h[15]}}, h};
    else              return info[0] ? {24'b0, b} : {{24{b[7]}}, b};
  endfunction

  function automatic logic [CW-1:0] upd_cnt(input logic [CW-1:0] c, input logic inc,
                                            input logic dec);
    case ({inc, dec})
      2'b10:   return c + CNT_ONE;
      2'b01:   return c - CNT_ONE;
      default: return c;
    endcase
  endfunction

  assign in_ready   = (r_cnt < FULL_CNT);
  assign w_push     = in_valid & in_ready;
  assign w_push_ld  = w_push & in_is_load;
  assign w_head_ld  = r_q_ld[r_rp];
  assign w_pop      = (r_cnt != '0) && (!w_head_ld || (r_rb_cnt != '0));
  assign w_rsp_pop  = w_pop & w_head_ld;
  // A load accepted this cycle already counts as outstanding for an arriving response.
  assign w_ld_pend  = r_ld_cnt + (w_push_ld ? CNT_ONE : '0);
  assign w_rsp_drop = mem_rsp_valid && ((w_ld_pend == r_rb_cnt) || (r_rb_cnt == FULL_CNT));
  assign w_rsp_push = mem_rsp_valid & ~w_rsp_drop;
  assign w_hd_data  = w_head_ld ? form_load(r_q_info[r_rp], r_q_alu[r_rp][1:0], r_rb[r_rb_rp])
                                : r_q_alu[r_rp];
  assign w_wen      = r_q_rw[r_rp] && !((ZERO_DROP != 0) && (r_q_reg[r_rp] == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_rb_wp     <= '0;
      r_rb_rp     <= '0;
      r_cnt       <= '0;
      r_ld_cnt    <= '0;
      r_rb_cnt    <= '0;
      r_ovf       <= 1'b0;
      r_reg_write <= 1'b0;
      r_wreg      <= '0;
      r_wdata     <= '0;
    end else begin
      if (w_push)     r_wp    <= r_wp + PTR_ONE;
      if (w_pop)      r_rp    <= r_rp + PTR_ONE;
      if (w_rsp_push) r_rb_wp <= r_rb_wp + PTR_ONE;
      if (w_rsp_pop)  r_rb_rp <= r_rb_rp + PTR_ONE;
      r_cnt    <= upd_cnt(r_cnt, w_push, w_pop);
      r_ld_cnt <= upd_cnt(r_ld_cnt, w_push_ld, w_rsp_pop);
      r_rb_cnt <= upd_cnt(r_rb_cnt, w_rsp_push, w_rsp_pop);
      if (w_rsp_drop) r_ovf <= 1'b1;
      r_reg_write <= w_pop & w_wen;
      // Destination and data update even when the write enable is suppressed.
      if (w_pop) begin
        r_wreg  <= r_q_reg[r_rp];
        r_wdata <= w_hd_data;
      end
    end
  end

  // Payload storage carries no reset; occupancy is tracked by the counters above.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_rw[r_wp]   <= in_reg_write;
      r_q_ld[r_wp]   <= in_is_load;
      r_q_info[r_wp] <= in_dmem_info;
      r_q_alu[r_wp]  <= in_alu_out;
      r_q_reg[r_wp]  <= in_write_reg;
    end
    if (w_rsp_push) r_rb[r_rb_wp] <= mem_rsp_data;
  end

  assign reg_write    = r_reg_write;
  assign write_reg_wb = r_wreg;
  assign write_data   = r_wdata;
  assign pend_count   = r_cnt;
  assign rsp_overflow = r_ovf;
endmodule

// File: tb/tb_wb_stage_buffered.sv
// Self-checking bench for wb_stage_buffered: directed scenarios plus a random
// run against a queue-based reference model.
module tb_wb_stage_buffered;
  localparam int DEPTH = 4;
  localparam int RW    = 5;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_reg_write, in_is_load;
  logic [2:0]    in_dmem_info;
  logic [31:0]   in_alu_out;
  logic [RW-1:0] in_write_reg;
  logic          mem_rsp_valid;
  logic [31:0]   mem_rsp_data;
  logic          reg_write;
  logic [RW-1:0] write_reg_wb;
  logic [31:0]   write_data;
  logic [CW-1:0] pend_count;
  logic          rsp_overflow;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic          rw;
    logic          ld;
    logic [2:0]    info;
    logic [31:0]   alu;
    logic [RW-1:0] rg;
  } ent_t;

  always #5 clk = ~clk;

  wb_stage_buffered #(.DEPTH(DEPTH), .REG_ADDR_W(RW), .ZERO_DROP(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_reg_write(in_reg_write), .in_is_load(in_is_load),
    .in_dmem_info(in_dmem_info), .in_alu_out(in_alu_out), .in_write_reg(in_write_reg),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .reg_write(reg_write), .write_reg_wb(write_reg_wb), .write_data(write_data),
    .pend_count(pend_count), .rsp_overflow(rsp_overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_reg_write = 0; in_is_load = 0; in_dmem_info = 0;
    in_alu_out = 0; in_write_reg = 0; mem_rsp_valid = 0; mem_rsp_data = 0;
  endtask

  task automatic drive_entry(input logic rw, input logic ld, input logic [2:0] info,
                             input logic [31:0] alu, input logic [RW-1:0] rg);
    in_valid = 1; in_reg_write = rw; in_is_load = ld; in_dmem_info = info;
    in_alu_out = alu; in_write_reg = rg;
  endtask

  // Push one load, answer it three cycles later; returns right after the response edge.
  task automatic do_load(input logic [2:0] info, input logic [31:0] addr,
                         input logic [RW-1:0] rg, input logic [31:0] rsp);
    drive_entry(1'b1, 1'b1, info, addr, rg);
    tick();
    in_valid = 0;
    tick();
    tick();
    mem_rsp_valid = 1; mem_rsp_data = rsp;
    tick();
    mem_rsp_valid = 0;
  endtask

  // Expected load data from byte-offset rules; byte k is the k-th most significant byte.
  function automatic logic [31:0] ref_load(input logic [2:0] info, input logic [31:0] addr,
                                           input logic [31:0] w);
    int bytes [4];
    int off, s, v;
    for (int k = 0; k < 4; k++) bytes[k] = int'((w >> (24 - 8 * k)) & 32'hFF);
    off = int'(addr[1:0]);
    if (info[1]) return w;
    if (info[2]) begin
      s = (off >= 2) ? 2 : 0;
      v = bytes[s] * 256 + bytes[s + 1];
      if (!info[0] && v >= 32768) v = v - 65536;
      return 32'(v);
    end
    v = bytes[off];
    if (!info[0] && v >= 128) v = v - 256;
    return 32'(v);
  endfunction

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    tick();
    checks++; if (reg_write !== 1'b0) begin failures++; $display("FAIL reset_we got=%0b want=0", reg_write); end
    checks++; if (write_reg_wb !== '0) begin failures++; $display("FAIL reset_wreg got=%0d want=0", write_reg_wb); end
    checks++; if (write_data !== 32'h0) begin failures++; $display("FAIL reset_wdata got=%h want=0", write_data); end
    checks++; if (pend_count !== '0) begin failures++; $display("FAIL reset_pend got=%0d want=0", pend_count); end
    checks++; if (rsp_overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b want=0", rsp_overflow); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b want=1", in_ready); end
    rst_n = 1;
    tick();
  endtask

  task automatic test_nonload();
    drive_entry(1'b1, 1'b0, 3'b000, 32'h12345678, 5'd7);
    tick();
    in_valid = 0;
    checks++; if (pend_count !== 1) begin failures++; $display("FAIL nonload_pend got=%0d want=1", pend_count); end
    checks++; if (reg_write !== 1'b0) begin failures++; $display("FAIL nonload_early got=%0b want=0", reg_write); end
    tick();
    checks++; if (reg_write !== 1'b1) begin failures++; $display("FAIL nonload_we got=%0b want=1", reg_write); end
    checks++; if (write_reg_wb !== 5'd7) begin failures++; $display("FAIL nonload_wreg got=%0d want=7", write_reg_wb); end
    checks++; if (write_data !== 32'h12345678) begin failures++; $display("FAIL nonload_wdata got=%h want=12345678", write_data); end
    tick();
    checks++; if (reg_write !== 1'b0) begin failures++; $display("FAIL nonload_pulse got=%0b want=0", reg_write); end
    checks++; if (write_data !== 32'h12345678) begin failures++; $display("FAIL nonload_hold got=%h want=12345678", write_data); end
  endtask

  task automatic test_byte_load();
    do_load(3'b000, 32'h0000_1002, 5'd3, 32'h0011F0FF);
    checks++; if (reg_write !== 1'b0) begin failures++; $display("FAIL byte_rsp_same_cycle got=%0b want=0", reg_write); end
    tick();
    checks++; if (reg_write !== 1'b1) begin failures++; $display("FAIL byte_s_we got=%0b want=1", reg_write); end
    checks++; if (write_reg_wb !== 5'd3) begin failures++; $display("FAIL byte_s_wreg got=%0d want=3", write_reg_wb); end
    checks++; if (write_data !== 32'hFFFFFFF0) begin failures++; $display("FAIL byte_s_data got=%h want=fffffff0", write_data); end
    do_load(3'b001, 32'h0000_1002, 5'd4, 32'h0011F0FF);
    tick();
    checks++; if (write_data !== 32'h000000F0) begin failures++; $display("FAIL byte_u_data got=%h want=000000f0", write_data); end
  endtask

  task automatic test_half_load();
    do_load(3'b100, 32'h0000_2002, 5'd5, 32'h00008001);
    tick();
    checks++; if (write_data !== 32'hFFFF8001) begin failures++; $display("FAIL half_off2 got=%h want=ffff8001", write_data); end
    do_load(3'b100, 32'h0000_2000, 5'd6, 32'h00008001);
    tick();
    checks++; if (write_data !== 32'h00000000) begin failures++; $display("FAIL half_off0 got=%h want=00000000", write_data); end
    do_load(3'b101, 32'h0000_2003, 5'd6, 32'h1234ABCD);
    tick();
    checks++; if (write_data !== 32'h0000ABCD) begin failures++; $display("FAIL half_u_off3 got=%h want=0000abcd", write_data); end
  endtask

  task automatic test_fill_wrap();
    logic [31:0] d [DEPTH];
    for (int i = 0; i < DEPTH; i++) begin
      d[i] = $urandom;
      drive_entry(1'b1, 1'b1, 3'b010, 32'h100 + 32'(i * 4), RW'(10 + i));
      tick();
    end
    drive_entry(1'b1, 1'b0, 3'b000, 32'hDEAD0000, 5'd31);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%0b want=0", in_ready); end
    tick();
    in_valid = 0;
    checks++; if (pend_count !== CW'(DEPTH)) begin failures++; $display("FAIL full_pend got=%0d want=%0d", pend_count, DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      mem_rsp_valid = 1; mem_rsp_data = d[i];
      tick();
      if (i > 0) begin
        checks++;
        if (reg_write !== 1'b1 || write_data !== d[i-1] || write_reg_wb !== RW'(9 + i)) begin
          failures++;
          $display("FAIL wrap_retire%0d got we=%0b reg=%0d data=%h want we=1 reg=%0d data=%h",
                   i - 1, reg_write, write_reg_wb, write_data, 9 + i, d[i-1]);
        end
      end
    end
    mem_rsp_valid = 0;
    tick();
    checks++;
    if (reg_write !== 1'b1 || write_data !== d[DEPTH-1] || write_reg_wb !== RW'(9 + DEPTH)) begin
      failures++;
      $display("FAIL wrap_retire_last got we=%0b reg=%0d data=%h want we=1 reg=%0d data=%h",
               reg_write, write_reg_wb, write_data, 9 + DEPTH, d[DEPTH-1]);
    end
    checks++; if (pend_count !== '0) begin failures++; $display("FAIL wrap_pend got=%0d want=0", pend_count); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL wrap_ready got=%0b want=1", in_ready); end
    checks++; if (rsp_overflow !== 1'b0) begin failures++; $display("FAIL wrap_ovf got=%0b want=0", rsp_overflow); end
  endtask

  task automatic test_overflow();
    mem_rsp_valid = 1; mem_rsp_data = 32'hBAD0BAD0;
    tick();
    mem_rsp_valid = 0;
    checks++; if (rsp_overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%0b want=1", rsp_overflow); end
    checks++; if (reg_write !== 1'b0) begin failures++; $display("FAIL ovf_noretire got=%0b want=0", reg_write); end
    tick();
    tick();
    checks++; if (rsp_overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0b want=1", rsp_overflow); end
    drive_entry(1'b1, 1'b1, 3'b010, 32'h40, 5'd9);
    tick();
    in_valid = 0;
    tick();
    checks++;
    if (reg_write !== 1'b0 || pend_count !== 1) begin
      failures++;
      $display("FAIL ovf_dropped_data got we=%0b pend=%0d want we=0 pend=1", reg_write, pend_count);
    end
    mem_rsp_valid = 1; mem_rsp_data = 32'h600DF00D;
    tick();
    mem_rsp_valid = 0;
    tick();
    checks++; if (write_data !== 32'h600DF00D) begin failures++; $display("FAIL ovf_next_load got=%h want=600df00d", write_data); end
  endtask

  task automatic test_zero_drop_reset();
    drive_entry(1'b1, 1'b0, 3'b000, 32'hCAFEF00D, 5'd0);
    tick();
    in_valid = 0;
    tick();
    checks++; if (reg_write !== 1'b0) begin failures++; $display("FAIL zero_we got=%0b want=0", reg_write); end
    checks++; if (write_data !== 32'hCAFEF00D) begin failures++; $display("FAIL zero_data got=%h want=cafef00d", write_data); end
    for (int i = 0; i < 3; i++) begin
      drive_entry(1'b1, 1'b1, 3'b010, 32'h80, RW'(20 + i));
      tick();
    end
    in_valid = 0;
    checks++; if (pend_count !== 3) begin failures++; $display("FAIL midrst_pre_pend got=%0d want=3", pend_count); end
    #2 rst_n = 0;
    #1;
    checks++;
    if (reg_write !== 1'b0 || write_reg_wb !== '0 || write_data !== 32'h0 ||
        pend_count !== '0 || rsp_overflow !== 1'b0) begin
      failures++;
      $display("FAIL midrst_outputs got we=%0b reg=%0d data=%h pend=%0d ovf=%0b want all 0",
               reg_write, write_reg_wb, write_data, pend_count, rsp_overflow);
    end
    #1 rst_n = 1;
    tick();
    checks++; if (pend_count !== '0) begin failures++; $display("FAIL midrst_post_pend got=%0d want=0", pend_count); end
  endtask

  task automatic test_random();
    ent_t        mq [$];
    logic [31:0] rq [$];
    ent_t        e, hd;
    logic        exp_we, exp_ovf, exp_ready, acc, ret, drop;
    logic [RW-1:0] exp_wreg;
    logic [31:0] exp_wdata;
    int          nld;
    rst_n = 0;
    idle_inputs();
    tick();
    rst_n = 1;
    exp_we = 0; exp_ovf = 0; exp_wreg = '0; exp_wdata = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      nld = 0;
      foreach (mq[k]) if (mq[k].ld) nld++;
      e.rw = 1'($urandom_range(0, 1)); e.ld = 1'($urandom_range(0, 1));
      e.info = 3'($urandom_range(0, 7)); e.alu = $urandom; e.rg = RW'($urandom_range(0, 31));
      in_valid = ($urandom_range(0, 9) < 6);
      in_reg_write = e.rw; in_is_load = e.ld; in_dmem_info = e.info;
      in_alu_out = e.alu; in_write_reg = e.rg;
      mem_rsp_valid = (nld > rq.size()) ? ($urandom_range(0, 9) < 5) : ($urandom_range(0, 99) < 2);
      mem_rsp_data = $urandom;

      exp_ready = (mq.size() < DEPTH);
      acc  = in_valid && exp_ready;
      ret  = (mq.size() > 0) && (!mq[0].ld || rq.size() > 0);
      drop = mem_rsp_valid && ((nld + int'(acc && e.ld)) == rq.size() || rq.size() == DEPTH);
      exp_we = 0;
      if (ret) begin
        hd = mq.pop_front();
        exp_wreg  = hd.rg;
        exp_wdata = hd.ld ? ref_load(hd.info, hd.alu, rq.pop_front()) : hd.alu;
        exp_we    = hd.rw && (hd.rg != 0);
      end
      if (acc) mq.push_back(e);
      if (mem_rsp_valid && !drop) rq.push_back(mem_rsp_data);
      if (drop) exp_ovf = 1;

      checks++; if (in_ready !== exp_ready) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%0b want=%0b", cyc, in_ready, exp_ready); end
      tick();
      checks++;
      if (reg_write !== exp_we || write_reg_wb !== exp_wreg || write_data !== exp_wdata ||
          pend_count !== CW'(mq.size()) || rsp_overflow !== exp_ovf) begin
        failures++;
        $display("FAIL rnd_out cyc=%0d got we=%0b reg=%0d data=%h pend=%0d ovf=%0b want we=%0b reg=%0d data=%h pend=%0d ovf=%0b",
                 cyc, reg_write, write_reg_wb, write_data, pend_count, rsp_overflow,
                 exp_we, exp_wreg, exp_wdata, mq.size(), exp_ovf);
      end
    end
    idle_inputs();
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0;
    idle_inputs();
    #2;
    test_reset();
    test_nonload();
    test_byte_load();
    test_half_load();
    test_fill_wrap();
    test_overflow();
    test_zero_drop_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
